ddr_read_engine: RTL and testbench

Upstream neighbour of the bias FIFO controller. Accepts one configuration (DDR start address, byte length) per transfer and splits it into AXI-style read bursts that respect the burst-length limit and 4 KiB boundaries. Returned beats are pushed into an internal FIFO, which the bias FIFO controller drains through a req/empty interface. A burst is issued only when the FIFO can absorb all of its beats, so read data is never back-pressured.

---
 rtl/ddr_read_engine_pkg.sv | 27 ++
 rtl/ddr_read_engine_if.sv | 29 ++
 rtl/ddr_read_engine_sync_fifo.sv | 62 ++++++
 rtl/ddr_read_engine.sv | 180 ++++++++++++++++++
 tb/tb_ddr_read_engine.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_read_engine_pkg.sv
// Shared definitions for the DDR read engine: beat geometry, page size,
// FSM state encoding and the clogb2 helper used across the buffer controllers.
package ddr_read_engine_pkg;

  localparam int unsigned DATA_LEN_DFLT   = 64;
  localparam int unsigned BUFFER_NUM_DFLT = 2;
  localparam int unsigned BEAT_W          = DATA_LEN_DFLT * BUFFER_NUM_DFLT;
  localparam int unsigned BEAT_BYTES      = BEAT_W / 8;
  localparam int unsigned PAGE_BYTES      = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_ADDR,
    ST_DATA
  } state_e;

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ddr_read_engine_if.sv
// AXI-style read address/data channel between the read engine and the DDR port.
interface ddr_read_engine_if
  import ddr_read_engine_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = BEAT_W
);

  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic              m_arvalid;
  logic              m_arready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;

  modport master (
    output m_araddr, m_arlen, m_arvalid, m_rready,
    input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );

  modport slave (
    input  m_araddr, m_arlen, m_arvalid, m_rready,
    output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );

endinterface

// File: rtl/ddr_read_engine_sync_fifo.sv
// Single-clock FIFO with registered read data and an occupancy count.
module sync_fifo
  import ddr_read_engine_pkg::*;
#(
  parameter int unsigned WIDTH = BEAT_W,
  parameter int unsigned DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        din,
  input  logic                    pop,
  output logic [WIDTH-1:0]        dout,
  output logic                    empty,
  output logic [clogb2(DEPTH):0]  occupancy
);

  localparam int unsigned AW = clogb2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             empty_q, empty_d;
  logic             pop_ok, push_ok, full;

  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign full      = (occupancy == (AW+1)'(DEPTH));

  always_comb begin
    pop_ok   = pop && !empty_q;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    dout_d   = pop_ok ? mem[rd_ptr_q[AW-1:0]] : dout_q;
    empty_d  = (wr_ptr_d == rd_ptr_d);
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
      empty_q  <= empty_d;
    end
  end

  assign dout  = dout_q;
  assign empty = empty_q;

endmodule

// File: rtl/ddr_read_engine.sv
// Splits a (start address, byte length) transfer into page-safe read bursts
// and buffers the returned beats for the bias FIFO controller.
module ddr_read_engine
  import ddr_read_engine_pkg::*;
#(
  parameter int unsigned DDR_ADDR_LEN = 32,
  parameter int unsigned SINGLE_LEN   = 24,
  parameter int unsigned DATA_LEN     = 64,
  parameter int unsigned BUFFER_NUM   = 2,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned FIFO_DEPTH   = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ddr_conf,
  input  logic [DDR_ADDR_LEN-1:0]        ddr_st_addr,
  input  logic [SINGLE_LEN-1:0]          ddr_len,
  ddr_read_engine_if.master              m_axi,
  output logic                           ddr_fifo_empty,
  input  logic                           ddr_fifo_req,
  output logic [DATA_LEN*BUFFER_NUM-1:0] ddr_fifo_data,
  output logic                           busy,
  output logic                           err
);

  localparam int unsigned W     = DATA_LEN * BUFFER_NUM;
  localparam int unsigned B     = W / 8;
  localparam int unsigned LOG2B = clogb2(B);
  localparam int unsigned REM_W = SINGLE_LEN + 1 - LOG2B;
  localparam int unsigned OCC_W = clogb2(FIFO_DEPTH) + 1;

  state_e                  state_q, state_d;
  logic [DDR_ADDR_LEN-1:0] addr_q, addr_d;
  logic [REM_W-1:0]        rem_q, rem_d;
  logic [DDR_ADDR_LEN-1:0] araddr_q, araddr_d;
  logic [7:0]              arlen_q, arlen_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;

  logic [SINGLE_LEN:0]     len_round;
  logic [REM_W-1:0]        conf_beats;
  logic [DDR_ADDR_LEN-1:0] conf_addr;
  logic [12:0]             page_left;
  logic [31:0]             burst_n;
  logic [31:0]             free_n;
  logic [8:0]              burst_beats;
  logic [OCC_W-1:0]        occupancy;
  logic                    fifo_push;

  assign len_round   = {1'b0, ddr_len} + (SINGLE_LEN+1)'(B - 1);
  assign conf_beats  = REM_W'(len_round >> LOG2B);
  assign conf_addr   = ddr_st_addr & ~DDR_ADDR_LEN'(B - 1);
  // Beats left before the next 4 KiB boundary; 256 at a page start.
  assign page_left   = (13'(PAGE_BYTES) - {1'b0, addr_q[11:0]}) >> LOG2B;
  assign free_n      = 32'(FIFO_DEPTH) - 32'(occupancy);
  assign burst_beats = {1'b0, arlen_q} + 9'd1;

  always_comb begin
    burst_n = MAX_BURST;
    if (32'(rem_q) < burst_n) begin
      burst_n = 32'(rem_q);
    end
    if (32'(page_left) < burst_n) begin
      burst_n = 32'(page_left);
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    busy_d    = busy_q;
    err_d     = err_q;
    fifo_push = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ddr_conf) begin
          err_d = 1'b0;
          if (conf_beats != '0) begin
            addr_d  = conf_addr;
            rem_d   = conf_beats;
            busy_d  = 1'b1;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        // Only issue when every beat of the burst already has a slot.
        if (free_n >= burst_n) begin
          araddr_d  = addr_q;
          arlen_d   = 8'(burst_n - 32'd1);
          arvalid_d = 1'b1;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_axi.m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (m_axi.m_rvalid && rready_q) begin
          fifo_push = 1'b1;
          if (m_axi.m_rresp != 2'b00) begin
            err_d = 1'b1;
          end
          if (m_axi.m_rlast) begin
            rready_d = 1'b0;
            addr_d   = addr_q + (DDR_ADDR_LEN'(burst_beats) << LOG2B);
            rem_d    = rem_q - REM_W'(burst_beats);
            if (rem_q == REM_W'(burst_beats)) begin
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_CALC;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .din       (m_axi.m_rdata),
    .pop       (ddr_fifo_req),
    .dout      (ddr_fifo_data),
    .empty     (ddr_fifo_empty),
    .occupancy (occupancy)
  );

  assign m_axi.m_araddr  = araddr_q;
  assign m_axi.m_arlen   = arlen_q;
  assign m_axi.m_arvalid = arvalid_q;
  assign m_axi.m_rready  = rready_q;
  assign busy            = busy_q;
  assign err             = err_q;

endmodule

// File: tb/tb_ddr_read_engine.sv
// Bench for ddr_read_engine: AXI slave model, FIFO consumer and a scoreboard
// of expected bursts and beats.
module tb_ddr_read_engine;

  localparam int unsigned BIG = 1000000;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  logic         clk;
  logic         rst;
  logic         ddr_conf;
  logic [31:0]  ddr_st_addr;
  logic [23:0]  ddr_len;
  logic         ddr_fifo_empty;
  logic         ddr_fifo_req;
  logic [127:0] ddr_fifo_data;
  logic         busy;
  logic         err;

  ddr_read_engine_if #(.ADDR_W(32), .DATA_W(128)) bus ();

  ddr_read_engine #(
    .DDR_ADDR_LEN (32),
    .SINGLE_LEN   (24),
    .DATA_LEN     (64),
    .BUFFER_NUM   (2),
    .MAX_BURST    (16),
    .FIFO_DEPTH   (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ddr_conf       (ddr_conf),
    .ddr_st_addr    (ddr_st_addr),
    .ddr_len        (ddr_len),
    .m_axi          (bus),
    .ddr_fifo_empty (ddr_fifo_empty),
    .ddr_fifo_req   (ddr_fifo_req),
    .ddr_fifo_data  (ddr_fifo_data),
    .busy           (busy),
    .err            (err)
  );

  int unsigned  n_tests = 0;
  int unsigned  n_fail  = 0;
  burst_t       exp_burst[$];
  logic [127:0] exp_data[$];
  logic [127:0] last_pop = '0;
  int unsigned  burst_cnt  = 0;
  int unsigned  popped     = 0;
  int unsigned  pop_budget = 0;
  int           beat_seq   = 0;
  int           err_beat   = -1;
  bit           ar_en      = 1'b0;
  bit           force_req  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] beat_data(input logic [31:0] a);
    return {~a, a ^ 32'h5A5A_C3C3, a + 32'h1111_1111, a};
  endfunction

  task automatic push_burst(input logic [31:0] a, input logic [7:0] l);
    burst_t b;
    b.addr = a;
    b.len  = l;
    exp_burst.push_back(b);
  endtask

  task automatic push_data(input logic [31:0] a, input int unsigned nbeats);
    for (int unsigned i = 0; i < nbeats; i++) begin
      exp_data.push_back(beat_data(a + 32'(i * 16)));
    end
  endtask

  task automatic conf(input logic [31:0] a, input logic [23:0] l);
    @(negedge clk);
    ddr_conf    = 1'b1;
    ddr_st_addr = a;
    ddr_len     = l;
    @(negedge clk);
    ddr_conf = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned max_cyc);
    int unsigned c;
    c = 0;
    while (!(busy == 1'b0 && exp_data.size() == 0 && ddr_fifo_empty == 1'b1) && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_timeout"}, 128'(c >= max_cyc), 128'd0);
    check({tag, "_bursts_left"}, 128'(exp_burst.size()), 128'd0);
  endtask

  // AXI read slave: accepts on arvalid, returns beats with random gaps.
  initial begin : axi_slave
    int unsigned left;
    logic [31:0] baddr;
    burst_t      e;
    left = 0;
    baddr = '0;
    bus.m_arready = 1'b0;
    bus.m_rvalid  = 1'b0;
    bus.m_rlast   = 1'b0;
    bus.m_rresp   = 2'b00;
    bus.m_rdata   = '0;
    forever begin
      @(negedge clk);
      bus.m_arready = 1'b0;
      if (rst) begin
        left = 0;
        bus.m_rvalid = 1'b0;
        bus.m_rlast  = 1'b0;
      end else if (left != 0) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.m_rvalid = 1'b0;
          bus.m_rlast  = 1'b0;
        end else begin
          bus.m_rdata  = beat_data(baddr);
          bus.m_rresp  = (beat_seq == err_beat) ? 2'd2 : 2'd0;
          bus.m_rvalid = 1'b1;
          bus.m_rlast  = (left == 1);
          baddr = baddr + 32'd16;
          left--;
          beat_seq++;
        end
      end else begin
        bus.m_rvalid = 1'b0;
        bus.m_rlast  = 1'b0;
        if (ar_en && bus.m_arvalid) begin
          if (exp_burst.size() == 0) begin
            check("burst_unexpected", 128'd1, 128'd0);
          end else begin
            e = exp_burst.pop_front();
            check("araddr", 128'(bus.m_araddr), 128'(e.addr));
            check("arlen", 128'(bus.m_arlen), 128'(e.len));
          end
          check("burst_4k", 128'((32'(bus.m_araddr[11:0]) + (32'(bus.m_arlen) + 32'd1) * 32'd16) <= 32'd4096), 128'd1);
          bus.m_arready = 1'b1;
          left  = 32'(bus.m_arlen) + 1;
          baddr = bus.m_araddr;
          burst_cnt++;
        end
      end
    end
  end

  // FIFO consumer: pops while budget remains, checks data one cycle later.
  initial begin : consumer
    bit pending;
    pending = 1'b0;
    ddr_fifo_req = 1'b0;
    forever begin
      @(negedge clk);
      if (pending) begin
        if (exp_data.size() == 0) begin
          check("fifo_extra", 128'd1, 128'd0);
        end else begin
          last_pop = exp_data.pop_front();
          check("fifo_data", ddr_fifo_data, last_pop);
        end
        popped++;
      end
      pending = 1'b0;
      if (force_req) begin
        ddr_fifo_req = 1'b1;
      end else if (!rst && pop_budget > 0 && !ddr_fifo_empty) begin
        ddr_fifo_req = 1'b1;
        pop_budget--;
        pending = 1'b1;
      end else begin
        ddr_fifo_req = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned b0;
    int unsigned p0;
    int unsigned c;
    rst = 1'b1;
    ddr_conf = 1'b0;
    ddr_st_addr = '0;
    ddr_len = '0;

    repeat (2) @(negedge clk);
    check("rst_araddr", 128'(bus.m_araddr), 128'd0);
    check("rst_arvalid", 128'(bus.m_arvalid), 128'd0);
    check("rst_rready", 128'(bus.m_rready), 128'd0);
    check("rst_empty", 128'(ddr_fifo_empty), 128'd1);
    check("rst_data", ddr_fifo_data, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_err", 128'(err), 128'd0);
    rst = 1'b0;

    // single burst, latency conf -> arvalid
    pop_budget = BIG;
    ar_en = 1'b0;
    push_burst(32'h1000, 8'd3);
    push_data(32'h1000, 4);
    conf(32'h1000, 24'd64);
    check("t1_arvalid_t1", 128'(bus.m_arvalid), 128'd0);
    @(negedge clk);
    check("t1_arvalid_t2", 128'(bus.m_arvalid), 128'd1);
    check("t1_busy", 128'(busy), 128'd1);
    ar_en = 1'b1;
    wait_done("t1", 300);
    check("t1_err", 128'(err), 128'd0);

    // req while empty is ignored
    p0 = popped;
    force_req = 1'b1;
    repeat (3) @(negedge clk);
    force_req = 1'b0;
    @(negedge clk);
    check("empty_req_empty", 128'(ddr_fifo_empty), 128'd1);
    check("empty_req_data", ddr_fifo_data, last_pop);

    // 19 beats in two bursts
    push_burst(32'h0, 8'd15);
    push_burst(32'h100, 8'd2);
    push_data(32'h0, 19);
    conf(32'h0, 24'd300);
    wait_done("t2", 400);

    // 4 KiB boundary split
    push_burst(32'h0FC0, 8'd3);
    push_burst(32'h1000, 8'd3);
    push_data(32'h0FC0, 8);
    conf(32'h0FC0, 24'd128);
    wait_done("t3", 400);

    // consumer stalled: third burst withheld until 16 pops
    pop_budget = 0;
    b0 = burst_cnt;
    p0 = popped;
    push_burst(32'h0, 8'd15);
    push_burst(32'h100, 8'd15);
    push_burst(32'h200, 8'd15);
    push_data(32'h0, 48);
    conf(32'h0, 24'd768);
    repeat (150) @(negedge clk);
    check("t4_bursts_stalled", 128'(burst_cnt - b0), 128'd2);
    check("t4_busy_stalled", 128'(busy), 128'd1);
    check("t4_arvalid_stalled", 128'(bus.m_arvalid), 128'd0);
    pop_budget = 16;
    c = 0;
    while (burst_cnt - b0 < 3 && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("t4_third_timeout", 128'(c >= 300), 128'd0);
    pop_budget = BIG;
    wait_done("t4", 600);
    check("t4_popped", 128'(popped - p0), 128'd48);

    // rresp error on second beat
    beat_seq = 0;
    err_beat = 1;
    push_burst(32'h2000, 8'd3);
    push_data(32'h2000, 4);
    conf(32'h2000, 24'd64);
    wait_done("t5", 300);
    check("t5_err_set", 128'(err), 128'd1);
    repeat (5) @(negedge clk);
    check("t5_err_sticky", 128'(err), 128'd1);
    err_beat = -1;
    push_burst(32'h3000, 8'd0);
    push_data(32'h3000, 1);
    conf(32'h3000, 24'd16);
    check("t5_err_cleared", 128'(err), 128'd0);
    wait_done("t5b", 300);

    // zero length
    b0 = burst_cnt;
    conf(32'h6000, 24'd0);
    check("t6_busy_now", 128'(busy), 128'd0);
    repeat (10) @(negedge clk);
    check("t6_arvalid", 128'(bus.m_arvalid), 128'd0);
    check("t6_busy", 128'(busy), 128'd0);
    check("t6_bursts", 128'(burst_cnt - b0), 128'd0);

    // conf while busy ignored; unaligned start address
    ar_en = 1'b0;
    b0 = burst_cnt;
    push_burst(32'h4000, 8'd3);
    push_data(32'h4000, 4);
    conf(32'h400F, 24'd64);
    repeat (3) @(negedge clk);
    conf(32'h8000, 24'd32);
    @(negedge clk);
    check("t7_araddr_held", 128'(bus.m_araddr), 128'h4000);
    check("t7_arlen_held", 128'(bus.m_arlen), 128'd3);
    check("t7_arvalid_held", 128'(bus.m_arvalid), 128'd1);
    ar_en = 1'b1;
    wait_done("t7", 300);
    check("t7_bursts", 128'(burst_cnt - b0), 128'd1);

    // asynchronous reset mid-DATA
    pop_budget = 0;
    push_burst(32'h5000, 8'd15);
    conf(32'h5000, 24'd256);
    c = 0;
    while (bus.m_rready !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("t8_reach_data", 128'(c >= 100), 128'd0);
    repeat (4) @(negedge clk);
    check("t8_pre_empty", 128'(ddr_fifo_empty), 128'd0);
    #2;
    rst = 1'b1;
    #1;
    check("t8_araddr", 128'(bus.m_araddr), 128'd0);
    check("t8_arlen", 128'(bus.m_arlen), 128'd0);
    check("t8_rready", 128'(bus.m_rready), 128'd0);
    check("t8_empty", 128'(ddr_fifo_empty), 128'd1);
    check("t8_data", ddr_fifo_data, 128'd0);
    check("t8_busy", 128'(busy), 128'd0);
    check("t8_err", 128'(err), 128'd0);
    exp_data.delete();
    exp_burst.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pop_budget = BIG;

    // recovery after reset
    push_burst(32'h7000, 8'd1);
    push_data(32'h7000, 2);
    conf(32'h7000, 24'd32);
    wait_done("t9", 300);
    check("final_exp_empty", 128'(exp_data.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
